// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the multichannel FIR decimator.
package fir_pkg;

  typedef logic [2:0] fir_state_t;

  localparam fir_state_t IDLE  = 3'd0;
  localparam fir_state_t MAC   = 3'd1;
  localparam fir_state_t DRAIN = 3'd2;
  localparam fir_state_t ROUND = 3'd3;
  localparam fir_state_t OUT   = 3'd4;

  typedef struct packed {
    logic signed [31:0] val;
    logic               sat;
  } sat_res_t;

  function automatic int acc_w(input int iw, input int cw, input int taps);
    return iw + cw + $clog2(taps);
  endfunction

  // Round half up by 2^frac, then clip to a signed iw-bit range.
  function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                         input int frac, input int iw);
    sat_res_t           r;
    logic signed [63:0] y, hi, lo;
    y = acc;
    if (frac > 0) y = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (iw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (iw - 1));
    r.sat = 1'b1;
    if (y > hi) r.val = hi[31:0];
    else if (y < lo) r.val = lo[31:0];
    else begin
      r.val = y[31:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_decim_mc_hist.sv
// Per-channel circular sample history: one all-channel write port,
// one registered read port addressed by {channel, location}.
module fir_hist_ram
  import fir_pkg::*;
#(
  parameter int IW       = 16,
  parameter int TAPS     = 32,
  parameter int CHANNELS = 2,
  parameter int TW       = $clog2(TAPS),
  parameter int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en_i,
  input  logic [TW-1:0]                 wr_ptr_i,
  input  logic [CHANNELS-1:0][IW-1:0]   wr_data_i,
  input  logic [CHW-1:0]                rd_ch_i,
  input  logic [TW-1:0]                 rd_tap_i,
  output logic [IW-1:0]                 rd_data_o
);

  logic [IW-1:0] mem_q [CHANNELS][TAPS];
  logic [IW-1:0] rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int t = 0; t < TAPS; t++)
          mem_q[c][t] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i)
        for (int c = 0; c < CHANNELS; c++)
          mem_q[c][wr_ptr_i] <= wr_data_i[c];
      rd_data_q <= mem_q[rd_ch_i][rd_tap_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_decim_mc.sv
// Time-multiplexed multichannel FIR decimator: one shared MAC walks all taps
// of every channel once per DECIM accepted frames, then rounds and saturates.
module fir_decim_mc
  import fir_pkg::*;
#(
  parameter int IW        = 16,
  parameter int CW        = 16,
  parameter int TAPS      = 32,
  parameter int CHANNELS  = 2,
  parameter int DECIM     = 6,
  parameter int COEF_FRAC = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TAPS-1:0][CW-1:0]       coefficients,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS-1:0][IW-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS-1:0][IW-1:0]   out_data,
  output logic [CHANNELS-1:0]           out_sat
);

  localparam int ACC_W = acc_w(IW, CW, TAPS);
  localparam int PW    = IW + CW;
  localparam int TW    = $clog2(TAPS);
  localparam int CHW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PHW   = (DECIM > 1) ? $clog2(DECIM) : 1;

  fir_state_t state_q, state_d;
  logic       drain_q;
  logic [TW-1:0]  wr_ptr_q, tap_q, s1_tap_q, rd_tap;
  logic [PHW-1:0] phase_q;
  logic [CHW-1:0] ch_q, s1_ch_q, s2_ch_q;
  logic           s1_vld_q, s2_vld_q, s2_first_q, out_valid_q;
  logic [IW-1:0]  rd_data;
  logic signed [PW-1:0]    prod_q;
  logic signed [ACC_W-1:0] acc_q [CHANNELS];
  logic signed [ACC_W-1:0] prod_ext, acc_base;
  logic [CHANNELS-1:0][IW-1:0] rnd_q, rnd_d, out_data_q;
  logic [CHANNELS-1:0]         rsat_q, rsat_d, out_sat_q;
  logic accept, dec_hit, last_op;
  int   loc;
  sat_res_t res;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid & in_ready;
  assign dec_hit   = (phase_q == PHW'(DECIM - 1));
  assign last_op   = (tap_q == TW'(TAPS - 1)) && (ch_q == CHW'(CHANNELS - 1));
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && dec_hit) state_d = MAC;
      MAC:     if (last_op) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tap k is the sample accepted k frames before the newest (at wr_ptr-1).
  always_comb begin
    loc = int'(wr_ptr_q) + TAPS - 1 - int'(tap_q);
    if (loc >= TAPS) loc = loc - TAPS;
    rd_tap = TW'(loc);
  end

  always_comb begin
    prod_ext = ACC_W'(prod_q);
    acc_base = s2_first_q ? '0 : acc_q[s2_ch_q];
  end

  always_comb begin
    rnd_d  = '0;
    rsat_d = '0;
    res    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      res       = sat_round(64'(acc_q[c]), COEF_FRAC, IW);
      rnd_d[c]  = res.val[IW-1:0];
      rsat_d[c] = res.sat;
    end
  end

  fir_hist_ram #(.IW(IW), .TAPS(TAPS), .CHANNELS(CHANNELS), .TW(TW), .CHW(CHW)) u_hist (
    .clk       (clk),
    .rst       (reset),
    .wr_en_i   (accept),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (in_data),
    .rd_ch_i   (ch_q),
    .rd_tap_i  (rd_tap),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      phase_q     <= '0;
      tap_q       <= '0;
      ch_q        <= '0;
      s1_vld_q    <= 1'b0;
      s1_ch_q     <= '0;
      s1_tap_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_ch_q     <= '0;
      s2_first_q  <= 1'b0;
      prod_q      <= '0;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      rnd_q       <= '0;
      rsat_q      <= '0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= (wr_ptr_q == TW'(TAPS - 1)) ? '0 : wr_ptr_q + TW'(1);
        phase_q  <= dec_hit ? '0 : phase_q + PHW'(1);
      end
      if (state_q == MAC) begin
        tap_q <= (tap_q == TW'(TAPS - 1)) ? '0 : tap_q + TW'(1);
        if (tap_q == TW'(TAPS - 1)) ch_q <= ch_q + CHW'(1);
      end else begin
        tap_q <= '0;
        ch_q  <= '0;
      end
      // Read -> multiply -> accumulate; tags travel alongside the data.
      s1_vld_q   <= (state_q == MAC);
      s1_ch_q    <= ch_q;
      s1_tap_q   <= tap_q;
      s2_vld_q   <= s1_vld_q;
      s2_ch_q    <= s1_ch_q;
      s2_first_q <= (s1_tap_q == '0);
      prod_q     <= PW'($signed(rd_data)) * PW'($signed(coefficients[s1_tap_q]));
      if (s2_vld_q) acc_q[s2_ch_q] <= acc_base + prod_ext;
      if (state_q == ROUND) begin
        rnd_q  <= rnd_d;
        rsat_q <= rsat_d;
      end
      if (state_q == OUT && !out_valid_q) begin
        out_data_q  <= rnd_q;
        out_sat_q   <= rsat_q;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_mc.sv
// Directed-vector bench for fir_decim_mc: a DECIM=1 and a DECIM=6 instance
// share clock, reset and coefficients; sel picks which one is driven.
module tb_fir_decim_mc;

  localparam int N = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0][15:0] coef;
  logic sel, iv, ordy;
  logic [1:0][15:0] idata;
  logic a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [1:0][15:0] a_out_data, b_out_data;
  logic [1:0] a_out_sat, b_out_sat;
  logic rdy, ovld;
  logic [1:0][15:0] odata;
  logic [1:0] osat;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rdy   = sel ? b_in_ready  : a_in_ready;
  assign ovld  = sel ? b_out_valid : a_out_valid;
  assign odata = sel ? b_out_data  : a_out_data;
  assign osat  = sel ? b_out_sat   : a_out_sat;

  fir_decim_mc #(.IW(16), .CW(16), .TAPS(32), .CHANNELS(2), .DECIM(1), .COEF_FRAC(15)) u_d1 (
    .clk(clk), .reset(reset), .coefficients(coef),
    .in_valid(iv & ~sel), .in_ready(a_in_ready), .in_data(idata),
    .out_valid(a_out_valid), .out_ready(sel ? 1'b1 : ordy),
    .out_data(a_out_data), .out_sat(a_out_sat));

  fir_decim_mc #(.IW(16), .CW(16), .TAPS(32), .CHANNELS(2), .DECIM(6), .COEF_FRAC(15)) u_d6 (
    .clk(clk), .reset(reset), .coefficients(coef),
    .in_valid(iv & sel), .in_ready(b_in_ready), .in_data(idata),
    .out_valid(b_out_valid), .out_ready(sel ? ordy : 1'b1),
    .out_data(b_out_data), .out_sat(b_out_sat));

  task automatic apply_reset(input int mode);
    reset = 1'b1;
    iv    = 1'b0;
    ordy  = 1'b1;
    for (int k = 0; k < 32; k++)
      coef[k] = (mode == 0) ? 16'(2 * (k + 1)) : (mode == 1) ? 16'd1024 : 16'd32767;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d0, input logic [15:0] d1, output bit to);
    int n = 0;
    @(negedge clk);
    idata[0] = d0;
    idata[1] = d1;
    iv = 1'b1;
    while (!rdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    to = !rdy;
    @(posedge clk);
    #1 iv = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit to);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ovld && n < 400);
    to  = !ovld;
    lat = n - 1;
  endtask

  task automatic test_reset;
    sel = 1'b0;
    apply_reset(0);
    n_vec++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got %b%b want 11", a_in_ready, b_in_ready); end
    n_vec++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got %b%b want 00", a_out_valid, b_out_valid); end
    n_vec++; if (a_out_data !== 32'h0 || b_out_data !== 32'h0) begin
      n_err++; $display("FAIL reset_out_data got %h %h want 0", a_out_data, b_out_data); end
    n_vec++; if (a_out_sat !== 2'b00 || b_out_sat !== 2'b00) begin
      n_err++; $display("FAIL reset_out_sat got %b %b want 00", a_out_sat, b_out_sat); end
  endtask

  task automatic test_impulse;
    bit to, to2;
    int lat, exp0;
    sel = 1'b0;
    apply_reset(0);
    for (int j = 1; j <= 34; j++) begin
      send((j == 1) ? 16'd16384 : 16'd0, 16'd0, to);
      wait_out(lat, to2);
      exp0 = (j <= 32) ? j : 0;
      n_vec++; if (to || to2) begin
        n_err++; $display("FAIL impulse_timeout frame %0d got timeout want output", j); end
      n_vec++; if (odata[0] !== 16'(exp0)) begin
        n_err++; $display("FAIL impulse_ch0 frame %0d got %0d want %0d", j, $signed(odata[0]), exp0); end
      n_vec++; if (odata[1] !== 16'h0 || osat !== 2'b00) begin
        n_err++; $display("FAIL impulse_ch1_sat frame %0d got %h/%b want 0/00", j, odata[1], osat); end
    end
  endtask

  task automatic test_latency;
    bit to;
    int cnt = 0;
    int vld_at = 0;
    sel = 1'b0;
    apply_reset(0);
    send(16'd16384, 16'd0, to);
    while (cnt < 300) begin
      @(negedge clk);
      cnt++;
      if (ovld && vld_at == 0) vld_at = cnt;
      if (rdy) break;
    end
    n_vec++; if (to || vld_at - 1 != N + 4) begin
      n_err++; $display("FAIL latency_out_valid got %0d want %0d", vld_at - 1, N + 4); end
    n_vec++; if (cnt - 1 != N + 5) begin
      n_err++; $display("FAIL latency_in_ready_low got %0d want %0d", cnt - 1, N + 5); end
  endtask

  task automatic test_dc;
    bit to, to2;
    int lat;
    int exp0 [7] = '{188, 375, 563, 750, 938, 1000, 1000};
    int exp1 [7] = '{-187, -375, -562, -750, -937, -1000, -1000};
    sel = 1'b1;
    apply_reset(1);
    for (int m = 0; m < 7; m++) begin
      to = 1'b0;
      for (int f = 0; f < 6; f++) begin
        bit t;
        send(16'd1000, 16'(-1000), t);
        to = to | t;
      end
      wait_out(lat, to2);
      n_vec++; if (to || to2 || (m == 0 && lat != N + 4)) begin
        n_err++; $display("FAIL dc_timing output %0d got latency %0d want %0d", m, lat, N + 4); end
      n_vec++; if (odata[0] !== 16'(exp0[m])) begin
        n_err++; $display("FAIL dc_ch0 output %0d got %0d want %0d", m, $signed(odata[0]), exp0[m]); end
      n_vec++; if (odata[1] !== 16'(exp1[m]) || osat !== 2'b00) begin
        n_err++; $display("FAIL dc_ch1 output %0d got %0d/%b want %0d/00", m, $signed(odata[1]), osat, exp1[m]); end
    end
  endtask

  task automatic test_saturation;
    bit to, to2;
    int lat;
    sel = 1'b0;
    apply_reset(2);
    send(16'd32767, 16'h8000, to);
    wait_out(lat, to2);
    n_vec++; if (to || to2 || odata[0] !== 16'd32766 || odata[1] !== 16'h8001 || osat !== 2'b00) begin
      n_err++; $display("FAIL sat_edge got %h %h %b want 7ffe 8001 00", odata[0], odata[1], osat); end
    send(16'd32767, 16'h8000, to);
    wait_out(lat, to2);
    n_vec++; if (to || to2 || odata[0] !== 16'h7fff || osat[0] !== 1'b1) begin
      n_err++; $display("FAIL sat_pos got %h/%b want 7fff/1", odata[0], osat[0]); end
    n_vec++; if (odata[1] !== 16'h8000 || osat[1] !== 1'b1) begin
      n_err++; $display("FAIL sat_neg got %h/%b want 8000/1", odata[1], osat[1]); end
  endtask

  task automatic test_backpressure;
    bit to, to2;
    int lat;
    sel = 1'b0;
    apply_reset(0);
    ordy = 1'b0;
    send(16'd16384, 16'd0, to);
    wait_out(lat, to2);
    n_vec++; if (to || to2 || odata[0] !== 16'd1) begin
      n_err++; $display("FAIL bp_first got %0d want 1", $signed(odata[0])); end
    idata = '0;
    iv = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_vec++; if (ovld !== 1'b1 || odata !== 32'h0000_0001 || rdy !== 1'b0) begin
        n_err++; $display("FAIL bp_hold cycle %0d got v=%b d=%h r=%b want 1/00000001/0", i, ovld, odata, rdy); end
    end
    ordy = 1'b1;
    @(negedge clk);
    n_vec++; if (rdy !== 1'b1 || ovld !== 1'b0) begin
      n_err++; $display("FAIL bp_release got r=%b v=%b want 1/0", rdy, ovld); end
    @(posedge clk);
    #1 iv = 1'b0;
    wait_out(lat, to2);
    n_vec++; if (to2 || lat != N + 4 || odata[0] !== 16'd2) begin
      n_err++; $display("FAIL bp_held_frame got %0d lat %0d want 2 lat %0d", $signed(odata[0]), lat, N + 4); end
    send(16'd0, 16'd0, to);
    wait_out(lat, to2);
    n_vec++; if (to || to2 || odata[0] !== 16'd3) begin
      n_err++; $display("FAIL bp_next_frame got %0d want 3", $signed(odata[0])); end
  endtask

  task automatic test_reset_mac;
    bit to, to2, seen;
    int lat;
    sel = 1'b1;
    apply_reset(1);
    for (int f = 0; f < 6; f++) send(16'd1000, 16'(-1000), to);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (ovld !== 1'b0 || rdy !== 1'b1) begin
      n_err++; $display("FAIL rmac_state got v=%b r=%b want 0/1", ovld, rdy); end
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (ovld) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin
      n_err++; $display("FAIL rmac_discard got out_valid=%b want 0", seen); end
    to = 1'b0;
    for (int f = 0; f < 6; f++) begin
      bit t;
      send(16'd1000, 16'(-1000), t);
      to = to | t;
    end
    wait_out(lat, to2);
    n_vec++; if (to || to2 || lat != N + 4) begin
      n_err++; $display("FAIL rmac_latency got %0d want %0d", lat, N + 4); end
    n_vec++; if (odata[0] !== 16'd188 || odata[1] !== 16'(-187) || osat !== 2'b00) begin
      n_err++; $display("FAIL rmac_fresh got %0d %0d %b want 188 -187 00", $signed(odata[0]), $signed(odata[1]), osat); end
  endtask

  initial begin
    sel   = 1'b0;
    iv    = 1'b0;
    ordy  = 1'b1;
    idata = '0;
    coef  = '0;
    test_reset();
    test_impulse();
    test_latency();
    test_dc();
    test_saturation();
    test_backpressure();
    test_reset_mac();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
